vdiv_element_sequencer: RTL

//   Upstream issue stage for the per-lane vector divide unit. It accepts one vector divide

---
 rtl/vdiv_element_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vdiv_element_sequencer.sv
// Issue stage for the per-lane vector divide unit: walks the element indices of one
// request, feeds each active element to the divider and writes results back by index.
module vdiv_element_sequencer #(
    parameter int unsigned MAX_VL = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W:0]    req_vl,
    input  logic              req_signed,
    input  logic              req_div_type,
    input  logic              req_mask_en,
    input  logic [MAX_VL-1:0] req_mask,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [31:0]       rd_vs1,
    input  logic [31:0]       rd_vs2,
    output logic              start_div,
    output logic [31:0]       vs1_data,
    output logic [31:0]       vs2_data,
    output logic              is_signed_div,
    output logic              div_type,
    input  logic              done_du,
    input  logic [31:0]       wdata_du,
    input  logic              exception_du,
    input  logic              flush,
    output logic              stop_flush,
    output logic              wb_en,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [31:0]       wb_data,
    output logic              seq_done,
    output logic              seq_exc
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [IDX_W:0] One = 1;

    state_e            state_q;
    logic [IDX_W:0]    idx_q;      // one bit wider than rd_idx so vl==MAX_VL compares cleanly
    logic [IDX_W:0]    vl_q;
    logic              mask_en_q;
    logic [MAX_VL-1:0] mask_q;
    logic              exc_q;
    logic              start_q;
    logic              seq_done_q;
    logic              seq_exc_q;
    logic              flush_q;
    logic [31:0]       vs1_q;
    logic [31:0]       vs2_q;
    logic              signed_q;
    logic              div_type_q;

    logic elem_masked;
    logic elem_last;
    logic wb_fire;

    assign elem_masked = mask_en_q & ~mask_q[idx_q[IDX_W-1:0]];
    assign elem_last   = (idx_q == (vl_q - One));

    // Sequencer FSM: request latch, element walk, operand capture and completion pulse.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            vl_q       <= '0;
            mask_en_q  <= 1'b0;
            mask_q     <= '0;
            exc_q      <= 1'b0;
            start_q    <= 1'b0;
            seq_done_q <= 1'b0;
            seq_exc_q  <= 1'b0;
            flush_q    <= 1'b0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            signed_q   <= 1'b0;
            div_type_q <= 1'b0;
        end else begin
            flush_q    <= flush;
            start_q    <= 1'b0;
            seq_done_q <= 1'b0;
            seq_exc_q  <= 1'b0;
            if (flush) begin
                // Abort wins over any same-cycle result or request.
                state_q <= StIdle;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (req_valid) begin
                            vl_q       <= req_vl;
                            signed_q   <= req_signed;
                            div_type_q <= req_div_type;
                            mask_en_q  <= req_mask_en;
                            mask_q     <= req_mask;
                            idx_q      <= '0;
                            exc_q      <= 1'b0;
                            state_q    <= (req_vl == '0) ? StDone : StIssue;
                        end
                    end
                    StIssue: begin
                        if (elem_masked) begin
                            if (elem_last) begin
                                state_q <= StDone;
                            end else begin
                                idx_q <= idx_q + One;
                            end
                        end else begin
                            vs1_q   <= rd_vs1;
                            vs2_q   <= rd_vs2;
                            start_q <= 1'b1;
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (done_du) begin
                            exc_q <= exc_q | exception_du;
                            if (elem_last) begin
                                state_q <= StDone;
                            end else begin
                                idx_q   <= idx_q + One;
                                state_q <= StIssue;
                            end
                        end
                    end
                    StDone: begin
                        seq_done_q <= 1'b1;
                        seq_exc_q  <= exc_q;
                        state_q    <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Writeback follows done_du in the same cycle; flush or reset suppresses it.
    always_comb begin
        wb_fire = (state_q == StWait) & done_du & ~flush & nRST;
        wb_en   = wb_fire;
        wb_idx  = wb_fire ? idx_q[IDX_W-1:0] : '0;
        wb_data = wb_fire ? wdata_du : '0;
    end

    // Registered pulses are masked by flush so the abort is visible in the flush cycle.
    always_comb begin
        req_ready     = (state_q == StIdle) & ~flush;
        rd_idx        = idx_q[IDX_W-1:0];
        start_div     = start_q & ~flush;
        seq_done      = seq_done_q & ~flush;
        seq_exc       = seq_exc_q & ~flush;
        stop_flush    = flush & ~flush_q & nRST;
        vs1_data      = vs1_q;
        vs2_data      = vs2_q;
        is_signed_div = signed_q;
        div_type      = div_type_q;
    end

endmodule
